im_upscale: RTL and testbench

Nearest-neighbour upscaler; the inverse of the 4×4 averaging compressor in the image-work path. It reads a pIN_IM_WIDTH×pIN_IM_HEIGHT frame from a source frame buffer one row at a time into an internal line buffer. Each buffered row is then written out pSCALE_Y times, with every pixel repeated pSCALE_X times, into a destination frame buffer. The block sits between the compressed-image store and the HDMI-side frame buffer and is driven by the same start/work/done control handshake as the compressor.

---
 rtl/im_upscale_pkg.sv | 17 +
 rtl/im_upscale_if.sv | 30 +++
 rtl/im_upscale_line_buf.sv | 26 ++
 rtl/im_upscale.sv | 181 ++++++++++++++++++
 tb/tb_im_upscale.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/im_upscale_pkg.sv
// Shared definitions for the image scaling blocks (compressor / upscaler).
// FSM state codes and an address-width helper.
package im_scale_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t READ  = 2'd1;
    localparam state_t WRITE = 2'd2;
    localparam state_t DONE  = 2'd3;

    // Bits needed to index n entries; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/im_upscale_if.sv
// Source/destination frame-buffer ports and start/work/done control.
// master = upscaler side, slave = memory/controller side.
interface im_upscale_if #(
    parameter int pRA_W   = 15,
    parameter int pWA_W   = 19,
    parameter int pDATA_W = 24
);
    logic [pDATA_W-1:0] idata_rd;
    logic [pRA_W-1:0]   oaddr_rd;
    logic               omem_rd_en;
    logic [pDATA_W-1:0] odata_wr;
    logic [pWA_W-1:0]   oaddr_wr;
    logic               omem_wr_en;
    logic [pRA_W-1:0]   idata_start_ptr;
    logic               istart_work;
    logic               omodule_work_f;
    logic               omodule_done_f;

    modport master (
        input  idata_rd, idata_start_ptr, istart_work,
        output oaddr_rd, omem_rd_en, odata_wr, oaddr_wr, omem_wr_en,
        output omodule_work_f, omodule_done_f
    );

    modport slave (
        output idata_rd, idata_start_ptr, istart_work,
        input  oaddr_rd, omem_rd_en, odata_wr, oaddr_wr, omem_wr_en,
        input  omodule_work_f, omodule_done_f
    );
endinterface

// File: rtl/im_upscale_line_buf.sv
// One-row pixel buffer: synchronous write, combinational read.
// No reset; contents are only read after being filled.
module im_line_buf
    import im_scale_pkg::*;
#(
    parameter int pDEPTH  = 160,
    parameter int pDATA_W = 24,
    localparam int AW     = addr_w(pDEPTH)
) (
    input  logic               iclk,
    input  logic               iwe,
    input  logic [AW-1:0]      iwaddr,
    input  logic [pDATA_W-1:0] iwdata,
    input  logic [AW-1:0]      iraddr,
    output logic [pDATA_W-1:0] ordata
);

    logic [pDATA_W-1:0] mem [pDEPTH];

    always_ff @(posedge iclk) begin
        if (iwe) mem[iwaddr] <= iwdata;
    end

    assign ordata = mem[iraddr];

endmodule

// File: rtl/im_upscale.sv
// Nearest-neighbour upscaler: buffers one source row, then writes it
// pSCALE_Y times with each pixel repeated pSCALE_X times.
module im_upscale
    import im_scale_pkg::*;
#(
    parameter int pIN_IM_WIDTH  = 160,
    parameter int pIN_IM_HEIGHT = 120,
    parameter int pSCALE_X      = 4,
    parameter int pSCALE_Y      = 4,
    parameter int pDATA_W       = 24
) (
    input logic iclk,
    input logic irst,
    im_upscale_if.master bus
);

    localparam int W     = pIN_IM_WIDTH;
    localparam int H     = pIN_IM_HEIGHT;
    localparam int OUT_W = W * pSCALE_X;
    localparam int OUT_H = H * pSCALE_Y;
    localparam int RA_W  = addr_w(W * H);
    localparam int WA_W  = addr_w(OUT_W * OUT_H);
    localparam int CW    = addr_w(W + 1);
    localparam int XW    = addr_w(W);
    localparam int SXW   = addr_w(pSCALE_X);
    localparam int SYW   = addr_w(pSCALE_Y);
    localparam int HW    = addr_w(H);

    localparam logic [CW-1:0]   C_W     = CW'(W);
    localparam logic [CW-1:0]   C_WM1   = CW'(W - 1);
    localparam logic [XW-1:0]   X_LAST  = XW'(W - 1);
    localparam logic [SXW-1:0]  SX_LAST = SXW'(pSCALE_X - 1);
    localparam logic [SYW-1:0]  SY_LAST = SYW'(pSCALE_Y - 1);
    localparam logic [HW-1:0]   H_LAST  = HW'(H - 1);
    localparam logic [RA_W-1:0] RA_STEP = RA_W'(W);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [XW-1:0]      scol;
    logic [SXW-1:0]     sx;
    logic [SYW-1:0]     yrep;
    logic [HW-1:0]      row;
    logic [RA_W-1:0]    row_base;

    logic [RA_W-1:0]    rd_addr;
    logic               rd_en;
    logic [pDATA_W-1:0] wr_data;
    logic [WA_W-1:0]    wr_addr;
    logic               wr_en;
    logic               work;
    logic               done;

    logic               last_x;
    logic               last_col;
    logic               last_y;
    logic               w_last;
    logic [SXW-1:0]     nsx;
    logic [XW-1:0]      nscol;
    logic [SYW-1:0]     nyrep;

    logic               lb_we;
    logic [XW-1:0]      lb_waddr;
    logic [XW-1:0]      lb_raddr;
    logic [pDATA_W-1:0] lb_rdata;
    logic [pDATA_W-1:0] first_px;

    always_comb begin
        last_x   = (sx == SX_LAST);
        last_col = (scol == X_LAST);
        last_y   = (yrep == SY_LAST);
        w_last   = last_x && last_col && last_y;
        nsx      = last_x ? '0 : sx + SXW'(1);
        nscol    = scol;
        nyrep    = yrep;
        if (last_x) nscol = last_col ? '0 : scol + XW'(1);
        if (last_x && last_col) nyrep = last_y ? '0 : yrep + SYW'(1);
    end

    assign lb_we    = (state == READ) && (cnt != '0);
    assign lb_waddr = XW'(cnt - CW'(1));
    assign lb_raddr = (state == WRITE) ? nscol : '0;

    // A one-pixel row is written into the buffer on the same edge it is
    // first needed, so bypass the buffer for that case.
    assign first_px = (W == 1) ? bus.idata_rd : lb_rdata;

    im_line_buf #(
        .pDEPTH  (W),
        .pDATA_W (pDATA_W)
    ) u_lbuf (
        .iclk   (iclk),
        .iwe    (lb_we),
        .iwaddr (lb_waddr),
        .iwdata (bus.idata_rd),
        .iraddr (lb_raddr),
        .ordata (lb_rdata)
    );

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state    <= IDLE;
            cnt      <= '0;
            scol     <= '0;
            sx       <= '0;
            yrep     <= '0;
            row      <= '0;
            row_base <= '0;
            rd_addr  <= '0;
            rd_en    <= 1'b0;
            wr_data  <= '0;
            wr_addr  <= '0;
            wr_en    <= 1'b0;
            work     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.istart_work) begin
                        state    <= READ;
                        row_base <= bus.idata_start_ptr;
                        rd_addr  <= bus.idata_start_ptr;
                        rd_en    <= 1'b1;
                        row      <= '0;
                        cnt      <= '0;
                        wr_addr  <= '0;
                        work     <= 1'b1;
                    end
                end
                READ: begin
                    cnt     <= cnt + CW'(1);
                    rd_en   <= (cnt < C_WM1);
                    rd_addr <= row_base + RA_W'(cnt) + RA_W'(1);
                    if (cnt == C_W) begin
                        state   <= WRITE;
                        cnt     <= '0;
                        sx      <= '0;
                        scol    <= '0;
                        yrep    <= '0;
                        wr_en   <= 1'b1;
                        wr_data <= first_px;
                    end
                end
                WRITE: begin
                    wr_addr <= wr_addr + WA_W'(1);
                    if (w_last) begin
                        wr_en <= 1'b0;
                        if (row == H_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                            work  <= 1'b0;
                        end else begin
                            state    <= READ;
                            row      <= row + HW'(1);
                            row_base <= row_base + RA_STEP;
                            rd_addr  <= row_base + RA_STEP;
                            rd_en    <= 1'b1;
                            cnt      <= '0;
                        end
                    end else begin
                        sx      <= nsx;
                        scol    <= nscol;
                        yrep    <= nyrep;
                        wr_data <= lb_rdata;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oaddr_rd       = rd_addr;
    assign bus.omem_rd_en     = rd_en;
    assign bus.odata_wr       = wr_data;
    assign bus.oaddr_wr       = wr_addr;
    assign bus.omem_wr_en     = wr_en;
    assign bus.omodule_work_f = work;
    assign bus.omodule_done_f = done;

endmodule

// File: tb/tb_im_upscale.sv
// Bench for im_upscale: 4x2 source at 2x2 scale and at 1x1 scale,
// expected reads/writes queued on start and popped by monitors.
module tb_im_upscale;
    import im_scale_pkg::*;

    localparam int DW    = 24;
    localparam int SW    = 4;
    localparam int SH    = 2;
    localparam int ASX   = 2;
    localparam int ASY   = 2;
    localparam int A_OW  = SW * ASX;
    localparam int A_RA  = addr_w(SW * SH);
    localparam int A_WA  = addr_w(A_OW * SH * ASY);
    localparam int A_LAT = SH * (SW + 1 + A_OW * ASY) + 1;
    localparam int B_RA  = addr_w(SW * SH);
    localparam int B_WA  = addr_w(SW * SH);
    localparam int B_LAT = SH * (SW + 1 + SW) + 1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   a_last_wr = 0;

    logic [DW-1:0] a_mem [2**A_RA];
    logic [DW-1:0] b_mem [2**B_RA];
    wr_t a_wq[$];
    int  a_rq[$];
    wr_t b_wq[$];
    int  b_rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    im_upscale_if #(.pRA_W(A_RA), .pWA_W(A_WA), .pDATA_W(DW)) a_if ();
    im_upscale_if #(.pRA_W(B_RA), .pWA_W(B_WA), .pDATA_W(DW)) b_if ();

    im_upscale #(
        .pIN_IM_WIDTH(SW), .pIN_IM_HEIGHT(SH),
        .pSCALE_X(ASX), .pSCALE_Y(ASY), .pDATA_W(DW)
    ) dut_a (.iclk(clk), .irst(rst), .bus(a_if.master));

    im_upscale #(
        .pIN_IM_WIDTH(SW), .pIN_IM_HEIGHT(SH),
        .pSCALE_X(1), .pSCALE_Y(1), .pDATA_W(DW)
    ) dut_b (.iclk(clk), .irst(rst), .bus(b_if.master));

    always @(posedge clk)
        if (a_if.omem_rd_en) a_if.idata_rd <= a_mem[a_if.oaddr_rd];
    always @(posedge clk)
        if (b_if.omem_rd_en) b_if.idata_rd <= b_mem[b_if.oaddr_rd];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        fails++;
        $display("FAIL %s: event not as expected", nm);
    endtask

    task automatic push_a(input int base);
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++)
                a_rq.push_back((base + r * SW + c) % (2**A_RA));
        for (int r = 0; r < SH; r++)
            for (int y = 0; y < ASY; y++)
                for (int c = 0; c < A_OW; c++) begin
                    wr_t e;
                    int  s;
                    s   = (base + r * SW + c / ASX) % (2**A_RA);
                    e.a = 32'(((r * ASY + y) * A_OW + c) % (2**A_WA));
                    e.d = 32'(a_mem[s]);
                    a_wq.push_back(e);
                end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            chk("a_rd_wr_excl", 32'(a_if.omem_rd_en & a_if.omem_wr_en), 0);
            if (a_if.omem_rd_en) begin
                if (a_rq.size() == 0) fail_now("a_extra_read");
                else chk("a_rd_addr", 32'(a_if.oaddr_rd), a_rq.pop_front());
            end
            if (a_if.omem_wr_en) begin
                a_last_wr = cyc;
                if (a_wq.size() == 0) fail_now("a_extra_write");
                else begin
                    e = a_wq.pop_front();
                    chk("a_wr_addr", 32'(a_if.oaddr_wr), e.a);
                    chk("a_wr_data", 32'(a_if.odata_wr), e.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            chk("b_rd_wr_excl", 32'(b_if.omem_rd_en & b_if.omem_wr_en), 0);
            if (b_if.omem_rd_en) begin
                if (b_rq.size() == 0) fail_now("b_extra_read");
                else chk("b_rd_addr", 32'(b_if.oaddr_rd), b_rq.pop_front());
            end
            if (b_if.omem_wr_en) begin
                if (b_wq.size() == 0) fail_now("b_extra_write");
                else begin
                    e = b_wq.pop_front();
                    chk("b_wr_addr", 32'(b_if.oaddr_wr), e.a);
                    chk("b_wr_data", 32'(b_if.odata_wr), e.d);
                end
            end
        end
    end

    // Pulses start for one edge; returns the cycle of the first work cycle.
    task automatic start_a(input int base, output int s);
        @(negedge clk);
        a_if.idata_start_ptr = A_RA'(base);
        a_if.istart_work = 1'b1;
        @(negedge clk);
        a_if.istart_work = 1'b0;
        s = cyc;
        chk("a_first_rd_en", 32'(a_if.omem_rd_en), 1);
        chk("a_first_rd_addr", 32'(a_if.oaddr_rd), 32'(base));
        chk("a_work_on", 32'(a_if.omodule_work_f), 1);
    endtask

    task automatic wait_a_done(input string nm, output int dc);
        dc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_if.omodule_done_f) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) fail_now(nm);
        else begin
            chk({nm, "_after_last_wr"}, 32'(dc - a_last_wr), 1);
            chk({nm, "_work_low"}, 32'(a_if.omodule_work_f), 0);
        end
    endtask

    task automatic wait_a_wr(input string nm);
        int ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (a_if.omem_wr_en) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) fail_now(nm);
    endtask

    task automatic chk_a_zero(input string nm);
        chk({nm, "_rd_addr"}, 32'(a_if.oaddr_rd), 0);
        chk({nm, "_rd_en"}, 32'(a_if.omem_rd_en), 0);
        chk({nm, "_wr_data"}, 32'(a_if.odata_wr), 0);
        chk({nm, "_wr_addr"}, 32'(a_if.oaddr_wr), 0);
        chk({nm, "_wr_en"}, 32'(a_if.omem_wr_en), 0);
        chk({nm, "_work"}, 32'(a_if.omodule_work_f), 0);
        chk({nm, "_done"}, 32'(a_if.omodule_done_f), 0);
    endtask

    initial begin
        int s;
        int dc;
        int dc2;
        a_if.istart_work = 1'b0;
        a_if.idata_start_ptr = '0;
        a_if.idata_rd = '0;
        b_if.istart_work = 1'b0;
        b_if.idata_start_ptr = '0;
        b_if.idata_rd = '0;
        for (int i = 0; i < 2**A_RA; i++) a_mem[i] = DW'(i + 1);
        for (int i = 0; i < 2**B_RA; i++) b_mem[i] = DW'(24'h100 + i * 7);

        repeat (3) @(negedge clk);
        chk_a_zero("reset");
        chk("reset_b_wr_en", 32'(b_if.omem_wr_en), 0);
        rst = 1'b0;

        // Ramp frame at base 0, with an ignored start pulse mid-WRITE.
        push_a(0);
        start_a(0, s);
        wait_a_wr("f1_wr_timeout");
        a_if.istart_work = 1'b1;
        @(negedge clk);
        a_if.istart_work = 1'b0;
        chk("f1_work_hold", 32'(a_if.omodule_work_f), 1);
        wait_a_done("f1_done", dc);
        chk("f1_latency", 32'(dc - s + 1), A_LAT);
        chk("f1_wq_empty", 32'(a_wq.size()), 0);
        @(negedge clk);
        chk("f1_done_pulse", 32'(a_if.omodule_done_f), 0);

        // Base near the top of the read address space: reads wrap.
        push_a(2**A_RA - 2);
        start_a(2**A_RA - 2, s);
        wait_a_done("f2_done", dc);
        chk("f2_latency", 32'(dc - s + 1), A_LAT);
        chk("f2_rq_empty", 32'(a_rq.size()), 0);

        // Start held high: back-to-back frames.
        push_a(1);
        push_a(1);
        @(negedge clk);
        a_if.idata_start_ptr = A_RA'(1);
        a_if.istart_work = 1'b1;
        wait_a_done("f3_done", dc);
        @(negedge clk);
        chk("f3_idle_gap_rd", 32'(a_if.omem_rd_en), 0);
        @(negedge clk);
        chk("f3_restart_rd", 32'(a_if.omem_rd_en), 1);
        chk("f3_restart_addr", 32'(a_if.oaddr_rd), 1);
        a_if.istart_work = 1'b0;
        wait_a_done("f4_done", dc2);
        chk("f4_spacing", 32'(dc2 - dc), A_LAT + 1);
        chk("f4_wq_empty", 32'(a_wq.size()), 0);

        // Asynchronous reset mid-WRITE, then a fresh frame.
        for (int i = 0; i < 2**A_RA; i++) a_mem[i] = DW'(i * 3 + 24'h50);
        push_a(2);
        start_a(2, s);
        wait_a_wr("f5_wr_timeout");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_a_zero("async_rst");
        a_wq.delete();
        a_rq.delete();
        b_wq.delete();
        b_rq.delete();
        @(negedge clk);
        rst = 1'b0;
        push_a(5);
        start_a(5, s);
        wait_a_wr("f6_wr_timeout");
        chk("f6_first_wr_addr", 32'(a_if.oaddr_wr), 0);
        wait_a_done("f6_done", dc);
        chk("f6_latency", 32'(dc - s + 1), A_LAT);
        chk("f6_wq_empty", 32'(a_wq.size()), 0);

        // 1x1 scale: straight copy.
        for (int i = 0; i < SW * SH; i++) begin
            wr_t e;
            b_rq.push_back(i);
            e.a = 32'(i);
            e.d = 32'(b_mem[i]);
            b_wq.push_back(e);
        end
        @(negedge clk);
        b_if.idata_start_ptr = '0;
        b_if.istart_work = 1'b1;
        @(negedge clk);
        b_if.istart_work = 1'b0;
        s = cyc;
        dc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b_if.omodule_done_f) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) fail_now("b_done_timeout");
        else chk("b_latency", 32'(dc - s + 1), B_LAT);
        chk("b_wq_empty", 32'(b_wq.size()), 0);
        chk("b_rq_empty", 32'(b_rq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
